wb_master_bridge: RTL and testbench

Wishbone classic single-transfer master that turns a local valid/ready command stream into Wishbone read/write cycles and returns one response per command. It sits between an internal requester (CPU model, test sequencer, DMA front end) and the Wishbone slaves of the design, including the register slaves. It runs one transfer at a time, holds all bus signals stable for the whole cycle, and enforces an ack timeout.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_timeout_counter.sv | 39 +++
 rtl/wb_master_bridge.sv | 134 +++++++++++++
 tb/tb_wb_master_bridge.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: master FSM state encoding and default sizing.
package wb_pkg;

  typedef enum logic [1:0] {
    WBM_IDLE,
    WBM_BUS,
    WBM_RESP
  } wb_master_state_t;

  localparam int WB_DEFAULT_TIMEOUT    = 16;
  localparam int WB_DEFAULT_ADDR_WIDTH = 8;
  localparam int WB_DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/wb_timeout_counter.sv
// Ack-timeout counter: counts bus cycles without ack and flags the last allowed cycle.
module wb_timeout_counter
  import wb_pkg::*;
#(
  parameter int TIMEOUT = WB_DEFAULT_TIMEOUT,
  localparam int CW = $clog2(TIMEOUT)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LAST so it can never wrap while the FSM is still deciding.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer master: one command in, one bus cycle, one response out.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT    = WB_DEFAULT_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i
);

  wb_master_state_t      state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  cnt_clr, cnt_en, cnt_expired;

  wb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expired_o(cnt_expired)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      WBM_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          cyc_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = WBM_BUS;
        end
      end
      WBM_BUS: begin
        // Ack is tested first so an ack on the final allowed cycle still succeeds.
        if (ack_i) begin
          rsp_dat_d   = we_q ? '0 : dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          state_d     = WBM_RESP;
        end else if (cnt_expired) begin
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          state_d     = WBM_RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      WBM_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = WBM_IDLE;
        end
      end
      default: begin
        state_d = WBM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= WBM_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  // Single-transfer master: strobe is asserted for exactly the life of the cycle.
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign cmd_ready_o = (state_q == WBM_IDLE) && !rst_i;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Scoreboard bench for wb_master_bridge with a behavioural delayed-ack Wishbone slave.
module tb_wb_master_bridge;

  typedef struct packed {
    logic       err;
    logic [7:0] dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [7:0] cmd_adr, cmd_dat;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_dat;
  logic       cyc, stb, we;
  logic [7:0] adr, dat_o, dat_i;
  logic       ack_i;

  int n_vec = 0;
  int n_err = 0;
  int n_rsp = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  wb_master_bridge #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .TIMEOUT   (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .cyc_o      (cyc),
    .stb_o      (stb),
    .we_o       (we),
    .adr_o      (adr),
    .dat_o      (dat_o),
    .dat_i      (dat_i),
    .ack_i      (ack_i)
  );

  // Slave: raises ack ack_delay edges after seeing strobe, holds it until strobe falls.
  logic [7:0] mem [0:255];
  int         ack_delay;
  int         slv_cnt;
  logic       slv_ack;
  logic       force_ack;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      slv_ack <= 1'b0;
      slv_cnt <= 0;
    end else if (!(cyc && stb)) begin
      slv_ack <= 1'b0;
      slv_cnt <= 0;
    end else if (!slv_ack && ack_delay > 0) begin
      if (slv_cnt == ack_delay - 1) begin
        slv_ack <= 1'b1;
        if (we) mem[adr] <= dat_o;
      end else begin
        slv_cnt <= slv_cnt + 1;
      end
    end
  end

  assign ack_i = slv_ack | force_ack;
  assign dat_i = mem[adr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Response monitor: pops one expectation per completed response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_rsp: got response err=%0d dat=0x%02h, required none", rsp_err, rsp_dat);
      end else begin
        mon_e = exp_q.pop_front();
        n_rsp++;
        $display("rsp %0d: err=%0d dat=0x%02h (expected err=%0d dat=0x%02h)",
                 n_rsp, rsp_err, rsp_dat, mon_e.err, mon_e.dat);
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        chk("rsp_dat", 32'(rsp_dat), 32'(mon_e.dat));
      end
    end
  end

  // Bus monitor: strobe run length, rising-edge count, and hold of we/adr/dat within a cycle.
  logic       stb_prev = 1'b0;
  logic       we_prev;
  logic [7:0] adr_prev, dat_prev;
  int         run_len = 0;
  int         last_run = 0;
  int         n_rises = 0;

  always @(negedge clk) begin
    if (stb && stb_prev)
      chk("bus_hold", {15'd0, we, adr, dat_o}, {15'd0, we_prev, adr_prev, dat_prev});
    if (stb && !stb_prev) begin
      n_rises  <= n_rises + 1;
      run_len  <= 1;
    end else if (stb) begin
      run_len  <= run_len + 1;
    end else if (stb_prev) begin
      last_run <= run_len;
      run_len  <= 0;
    end
    stb_prev <= stb;
    we_prev  <= we;
    adr_prev <= adr;
    dat_prev <= dat_o;
  end

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic issue(input logic c_we, input logic [7:0] c_adr, input logic [7:0] c_dat,
                       input bit expect_rsp, input logic e_err, input logic [7:0] e_dat,
                       input bit hold);
    int t = 0;
    exp_t e;
    e.err = e_err;
    e.dat = e_dat;
    if (expect_rsp) exp_q.push_back(e);
    $display("cmd: we=%0d adr=0x%02h dat=0x%02h", c_we, c_adr, c_dat);
    cmd_we    = c_we;
    cmd_adr   = c_adr;
    cmd_dat   = c_dat;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles, required 1", t);
    end
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL rsp_wait: %0d responses outstanding, required 0", exp_q.size());
    end
    #1;
  endtask

  logic [7:0] s_adr [8] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h20, 8'h21, 8'h22, 8'h23};
  logic [7:0] s_dat [8] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] s_exp [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h30, 8'h31, 8'h32, 8'h33};
  logic       s_we  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rises0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 8'h00;
    cmd_dat   = 8'h00;
    rsp_ready = 1'b1;
    ack_delay = 2;
    force_ack = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {26'd0, cyc, stb, we, rsp_valid, rsp_err, cmd_ready}, 32'd0);
    chk("rst_adr", 32'(adr), 32'd0);
    chk("rst_dat", 32'(dat_o), 32'd0);
    chk("rst_rsp_dat", 32'(rsp_dat), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // Write then read with a 2-edge ack slave
    rises0 = n_rises;
    issue(1'b1, 8'h03, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("ack2_latency", 32'(lat), 32'd3);
    wait_done();
    issue(1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0);
    wait_done();
    chk("wr_rd_strobes", 32'(n_rises - rises0), 32'd2);

    // Timeout with no ack, then a stray late ack
    ack_delay = 0;
    issue(1'b0, 8'h07, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
    wait_done();
    chk("timeout_stb_cycles", 32'(last_run), 32'd4);
    @(posedge clk);
    #1;
    force_ack = 1'b1;
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_ack_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;

    // Ack exactly on the last allowed cycle wins; one cycle later times out
    ack_delay = 3;
    issue(1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0);
    wait_done();
    ack_delay = 4;
    issue(1'b0, 8'h03, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
    wait_done();

    // Response backpressure
    ack_delay = 2;
    issue(1'b1, 8'h09, 8'h5C, 1'b1, 1'b0, 8'h00, 1'b0);
    wait_done();
    rsp_ready = 1'b0;
    issue(1'b0, 8'h09, 8'h00, 1'b1, 1'b0, 8'h5C, 1'b0);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_dat", 32'(rsp_dat), 32'h5C);
      chk("bp_ready", 32'(cmd_ready), 32'd0);
      chk("bp_bus_idle", {30'd0, cyc, stb}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a bus cycle
    ack_delay = 0;
    issue(1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #3;
    chk("mid_stb_high", 32'(stb), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_drop", {30'd0, cyc, stb}, 32'd0);
    chk("rst_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    ack_delay = 2;
    issue(1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0);
    wait_done();

    // Back-to-back stream, cmd_valid and rsp_ready held high
    ack_delay = 1;
    rises0 = n_rises;
    for (int i = 0; i < 8; i++)
      issue(s_we[i], s_adr[i], s_dat[i], 1'b1, 1'b0, s_exp[i], 1'b1);
    cmd_valid = 1'b0;
    wait_done();
    chk("stream_strobes", 32'(n_rises - rises0), 32'd8);

    repeat (4) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
